// File: rtl/dmem_bank.sv
// Byte-addressable data memory for the MEM stage: byte/half/word access with lane
// enables, load extension, misalignment faults, fixed latency and an optional clear sweep.
module dmem_bank #(
  parameter int DEPTH          = 1024,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic        init_done,
  output logic [1:0]  dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] LAT_LAST = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  // Handshake: a request is taken on any rising edge where req=1 and ready=1;
  // exactly one resp_valid pulse follows each taken request, never more, never queued.
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_nxt;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] clr_cnt;
  logic [2:0]    lat_cnt;
  logic          we_q, sext_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic [31:0]   wdata_q;
  logic          accept, fault_q;
  logic          unused_addr_hi;

  function automatic logic is_fault(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == 2'b11) || (sz == 2'b01 && lo[0]) || (sz == 2'b10 && lo != 2'b00);
  endfunction

  assign unused_addr_hi = ^addr[31:AW+2];
  assign accept  = ready & req;
  assign fault_q = is_fault(size_q, addr_q[1:0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: if (CLEAR_ON_RESET == 0 || clr_cnt == AW'(DEPTH - 1)) state_nxt = S_IDLE;
      S_IDLE: if (req) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (lat_cnt == LAT_LAST) state_nxt = S_RESP;
      S_RESP: begin
        if (req) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
        else     state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  logic [31:0] word_rd, shifted, load_val;
  always_comb begin
    word_rd  = mem[addr_q[AW+1:2]];
    shifted  = word_rd >> {addr_q[1:0], 3'b000};
    load_val = word_rd;
    case (size_q)
      2'b00:   load_val = sext_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      2'b01:   load_val = sext_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      default: load_val = word_rd;
    endcase
    ready      = (state == S_IDLE) || (state == S_RESP);
    resp_valid = (state == S_RESP);
    resp_err   = (state == S_RESP) && fault_q;
    rdata      = (state == S_RESP && !fault_q && !we_q) ? load_val : 32'b0;
    dbg_state  = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt   <= '0;
      lat_cnt   <= '0;
      init_done <= 1'b0;
      we_q      <= 1'b0;
      sext_q    <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
    end else begin
      if (state == S_INIT) clr_cnt <= clr_cnt + AW'(1);
      if (state == S_INIT && state_nxt == S_IDLE) init_done <= 1'b1;
      if (accept) begin
        we_q    <= we;
        sext_q  <= sign_ext;
        addr_q  <= addr[AW+1:0];
        size_q  <= size;
        wdata_q <= wdata;
        lat_cnt <= '0;
      end else if (state == S_WAIT) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
    end
  end

  // The commit happens on the edge entering RESP; with LATENCY=1 that is the accept
  // edge itself, so the live inputs are used instead of the not-yet-captured copies.
  logic          src_we;
  logic [AW+1:0] src_addr;
  logic [1:0]    src_size;
  logic [31:0]   src_wdata, lane_data;
  logic [3:0]    lane_en;
  logic          commit;
  always_comb begin
    src_we    = (state == S_WAIT) ? we_q    : we;
    src_addr  = (state == S_WAIT) ? addr_q  : addr[AW+1:0];
    src_size  = (state == S_WAIT) ? size_q  : size;
    src_wdata = (state == S_WAIT) ? wdata_q : wdata;
    case (src_size)
      2'b00: begin
        lane_en   = 4'b0001 << src_addr[1:0];
        lane_data = {4{src_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = src_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{src_wdata[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = src_wdata;
      end
    endcase
    commit = (state != S_INIT) && (state_nxt == S_RESP) && src_we &&
             !is_fault(src_size, src_addr[1:0]);
  end

  always_ff @(posedge clk) begin
    if (state == S_INIT && CLEAR_ON_RESET != 0) begin
      mem[clr_cnt] <= '0;
    end else if (commit) begin
      for (int i = 0; i < 4; i++)
        if (lane_en[i]) mem[src_addr[AW+1:2]][8*i +: 8] <= lane_data[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_dmem_bank.sv
// Directed bench for dmem_bank: three instances cover clear sweep/L=1, latency 4,
// and latency 3 without clearing; inputs are shared, unused instances held in reset.
module tb_dmem_bank;
  logic        clk;
  logic [2:0]  rst_n;
  logic        req, we, sign_ext;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        ready [3];
  logic        resp_valid [3];
  logic        resp_err [3];
  logic        init_done [3];
  logic [31:0] rdata [3];
  logic [1:0]  dbg_state [3];
  int checks = 0;
  int fails  = 0;

  dmem_bank #(.DEPTH(16), .LATENCY(1), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .rst_n(rst_n[0]), .req(req), .we(we), .addr(addr), .size(size),
    .sign_ext(sign_ext), .wdata(wdata), .ready(ready[0]), .resp_valid(resp_valid[0]),
    .resp_err(resp_err[0]), .rdata(rdata[0]), .init_done(init_done[0]), .dbg_state(dbg_state[0]));
  dmem_bank #(.DEPTH(16), .LATENCY(4), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .rst_n(rst_n[1]), .req(req), .we(we), .addr(addr), .size(size),
    .sign_ext(sign_ext), .wdata(wdata), .ready(ready[1]), .resp_valid(resp_valid[1]),
    .resp_err(resp_err[1]), .rdata(rdata[1]), .init_done(init_done[1]), .dbg_state(dbg_state[1]));
  dmem_bank #(.DEPTH(16), .LATENCY(3), .CLEAR_ON_RESET(0)) u_c (
    .clk(clk), .rst_n(rst_n[2]), .req(req), .we(we), .addr(addr), .size(size),
    .sign_ext(sign_ext), .wdata(wdata), .ready(ready[2]), .resp_valid(resp_valid[2]),
    .resp_err(resp_err[2]), .rdata(rdata[2]), .init_done(init_done[2]), .dbg_state(dbg_state[2]));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: release reset at a falling edge and count samples with ready low.
  task automatic release_and_wait(input int d, output int n);
    rst_n[d] = 1'b1;
    n = 0;
    while (!ready[d] && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Driver: one request; returns at the falling edge inside the response cycle.
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [1:0] sz, input logic sx, input logic [31:0] wd,
                        output logic err, output logic [31:0] rd, output int lat);
    int n;
    n = 0;
    while (!ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    req = 1'b1; we = w; addr = a; size = sz; sign_ext = sx; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; addr = ~a; wdata = ~wd; sign_ext = ~sx;
    @(negedge clk);
    lat = 1;
    while (!resp_valid[d] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    err = resp_err[d];
    rd  = rdata[d];
  endtask

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      checks++; if (ready[d] !== 1'b0) begin fails++; $display("FAIL reset_ready[%0d] got %b want 0", d, ready[d]); end
      checks++; if (resp_valid[d] !== 1'b0) begin fails++; $display("FAIL reset_resp_valid[%0d] got %b want 0", d, resp_valid[d]); end
      checks++; if (resp_err[d] !== 1'b0) begin fails++; $display("FAIL reset_resp_err[%0d] got %b want 0", d, resp_err[d]); end
      checks++; if (rdata[d] !== 32'h0) begin fails++; $display("FAIL reset_rdata[%0d] got %h want 0", d, rdata[d]); end
      checks++; if (init_done[d] !== 1'b0) begin fails++; $display("FAIL reset_init_done[%0d] got %b want 0", d, init_done[d]); end
    end
    rst_n[2] = 1'b1;
    @(negedge clk);
    checks++; if (init_done[2] !== 1'b1) begin fails++; $display("FAIL noclear_init_done got %b want 1", init_done[2]); end
    checks++; if (ready[2] !== 1'b1) begin fails++; $display("FAIL noclear_ready got %b want 1", ready[2]); end
    rst_n[2] = 1'b0;
  endtask

  task automatic test_sweep;
    int n, lat;
    logic err;
    logic [31:0] rd;
    release_and_wait(0, n);
    checks++; if (n != 16) begin fails++; $display("FAIL sweep1_cycles got %0d want 16", n); end
    access(0, 1'b1, 32'h14, 2'b10, 1'b0, 32'hDEADBEEF, err, rd, lat);
    access(0, 1'b0, 32'h14, 2'b10, 1'b0, 32'h0, err, rd, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL poke_readback got %h want deadbeef", rd); end
    rst_n[0] = 1'b0;
    @(negedge clk);
    release_and_wait(0, n);
    checks++; if (n != 16) begin fails++; $display("FAIL sweep2_cycles got %0d want 16", n); end
    checks++; if (init_done[0] !== 1'b1) begin fails++; $display("FAIL sweep_init_done got %b want 1", init_done[0]); end
    access(0, 1'b0, 32'h14, 2'b10, 1'b0, 32'h0, err, rd, lat);
    checks++; if (rd !== 32'h0) begin fails++; $display("FAIL sweep_word5 got %h want 0", rd); end
    checks++; if (lat != 1) begin fails++; $display("FAIL l1_latency got %0d want 1", lat); end
  endtask

  task automatic test_byte_half;
    int lat;
    logic err;
    logic [31:0] rd;
    access(0, 1'b1, 32'h8, 2'b10, 1'b0, 32'h11223344, err, rd, lat);
    access(0, 1'b1, 32'h9, 2'b00, 1'b0, 32'h777777AB, err, rd, lat);
    access(0, 1'b1, 32'hA, 2'b01, 1'b0, 32'h5555BEEF, err, rd, lat);
    access(0, 1'b0, 32'h8, 2'b10, 1'b1, 32'h0, err, rd, lat);
    checks++; if (rd !== 32'hBEEFAB44) begin fails++; $display("FAIL word_merge got %h want beefab44", rd); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL word_merge_err got %b want 0", err); end
    access(0, 1'b0, 32'h9, 2'b00, 1'b1, 32'h0, err, rd, lat);
    checks++; if (rd !== 32'hFFFFFFAB) begin fails++; $display("FAIL byte_sext got %h want ffffffab", rd); end
    access(0, 1'b0, 32'h9, 2'b00, 1'b0, 32'h0, err, rd, lat);
    checks++; if (rd !== 32'h000000AB) begin fails++; $display("FAIL byte_zext got %h want 000000ab", rd); end
    access(0, 1'b0, 32'hA, 2'b01, 1'b1, 32'h0, err, rd, lat);
    checks++; if (rd !== 32'hFFFFBEEF) begin fails++; $display("FAIL half_sext got %h want ffffbeef", rd); end
    access(0, 1'b0, 32'h8, 2'b01, 1'b0, 32'h0, err, rd, lat);
    checks++; if (rd !== 32'h0000AB44) begin fails++; $display("FAIL half_lo_zext got %h want 0000ab44", rd); end
    @(negedge clk);
    checks++; if (rdata[0] !== 32'h0) begin fails++; $display("FAIL rdata_idle got %h want 0", rdata[0]); end
  endtask

  task automatic test_misalign;
    int lat;
    logic err;
    logic [31:0] rd;
    access(0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h55667788, err, rd, lat);
    access(0, 1'b1, 32'h3, 2'b01, 1'b0, 32'h0000FFFF, err, rd, lat);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL half_store_mis got err=%b rd=%h want err=1 rd=0", err, rd); end
    access(0, 1'b0, 32'h6, 2'b10, 1'b0, 32'h0, err, rd, lat);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL word_load_mis got err=%b rd=%h want err=1 rd=0", err, rd); end
    access(0, 1'b1, 32'h0, 2'b11, 1'b0, 32'hFFFFFFFF, err, rd, lat);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL size11 got err=%b rd=%h want err=1 rd=0", err, rd); end
    access(0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, err, rd, lat);
    checks++; if (err !== 1'b0 || rd !== 32'h55667788) begin fails++; $display("FAIL word0_intact got err=%b rd=%h want err=0 rd=55667788", err, rd); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic err;
    logic [31:0] rd;
    access(0, 1'b1, 32'h40, 2'b10, 1'b0, 32'hCAFEF00D, err, rd, lat);
    checks++; if (resp_valid[0] !== 1'b1 || ready[0] !== 1'b1) begin fails++; $display("FAIL store_resp_cycle got valid=%b ready=%b want 1 1", resp_valid[0], ready[0]); end
    access(0, 1'b0, 32'h00, 2'b10, 1'b0, 32'h0, err, rd, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL wrap_raw got %h want cafef00d", rd); end
    checks++; if (lat != 1) begin fails++; $display("FAIL wrap_raw_latency got %0d want 1", lat); end
  endtask

  task automatic test_latency;
    int n, acc;
    logic [13:0] rdy_vec, rv_vec;
    release_and_wait(1, n);
    checks++; if (n != 16) begin fails++; $display("FAIL l4_sweep got %0d want 16", n); end
    acc = 0; rdy_vec = '0; rv_vec = '0;
    req = 1'b1; we = 1'b0; addr = 32'h10; size = 2'b10; sign_ext = 1'b0; wdata = 32'h0;
    for (int c = 0; c < 14; c++) begin
      rdy_vec[c] = ready[1];
      rv_vec[c]  = resp_valid[1];
      if (req && ready[1]) acc++;
      @(posedge clk);
      #1;
      if (acc == 3) req = 1'b0;
      @(negedge clk);
    end
    checks++; if (acc != 3) begin fails++; $display("FAIL l4_accepts got %0d want 3", acc); end
    checks++; if (rdy_vec !== 14'h3111) begin fails++; $display("FAIL l4_ready_pattern got %h want 3111", rdy_vec); end
    checks++; if (rv_vec !== 14'h1110) begin fails++; $display("FAIL l4_resp_pattern got %h want 1110", rv_vec); end
    rst_n[1] = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n, lat, seen;
    logic err;
    logic [31:0] rd;
    release_and_wait(2, n);
    checks++; if (n != 1) begin fails++; $display("FAIL noclear_wait got %0d want 1", n); end
    access(2, 1'b1, 32'h4, 2'b10, 1'b0, 32'h12345678, err, rd, lat);
    checks++; if (lat != 3) begin fails++; $display("FAIL l3_latency got %0d want 3", lat); end
    req = 1'b1; we = 1'b1; addr = 32'h4; size = 2'b10; sign_ext = 1'b0; wdata = 32'h1;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid[2]) seen++;
    end
    checks++; if (seen != 0) begin fails++; $display("FAIL mid_reset_resp got %0d responses want 0", seen); end
    access(2, 1'b0, 32'h4, 2'b10, 1'b0, 32'h0, err, rd, lat);
    checks++; if (rd !== 32'h12345678) begin fails++; $display("FAIL mid_reset_word1 got %h want 12345678", rd); end
  endtask

  initial begin
    rst_n = 3'b000;
    req = 1'b0; we = 1'b0; addr = '0; size = 2'b10; sign_ext = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_sweep;
    test_byte_half;
    test_misalign;
    test_back_to_back;
    test_latency;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
